// File: rtl/wb_dma_mast_arb.sv
// -----------------------------------------------------------------------------
// wb_dma_mast_arb
//
// Purpose:
//   Two-requester round-robin arbiter and burst sequencer that sits in front of
//   the DMA Wishbone master interface. One requester at a time owns the master
//   datapath. While it owns it, the block steps the word address and counts
//   completed words (mast_drdy). A burst ends when its word count is used up
//   or when the bus reports an error (mast_err).
//
// Parameters:
//   AW - address width
//   DW - data width; the address advances by DW/8 bytes per word
//   LW - burst length counter width
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   rqN_req/we/adr/len  burst request, direction, start address, word count
//   rqN_dout/wait     write data for the current word; requester stall
//   rqN_gnt           requester N owns the master
//   rqN_ack           one word transferred this cycle for requester N
//   rqN_done/err      1-cycle pulse: burst complete / burst aborted
//   mast_go/we/wait   cycle active, write, strobe suppress to master
//   mast_adr/dout     current word address, write data to master
//   mast_din/drdy/err read data, word complete, bus error from master
//   rd_data           read data broadcast to requesters (= mast_din)
// -----------------------------------------------------------------------------
module wb_dma_mast_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  // requester 0
  input  logic          rq0_req,
  input  logic          rq0_we,
  input  logic [AW-1:0] rq0_adr,
  input  logic [LW-1:0] rq0_len,
  input  logic [DW-1:0] rq0_dout,
  input  logic          rq0_wait,
  output logic          rq0_gnt,
  output logic          rq0_ack,
  output logic          rq0_done,
  output logic          rq0_err,
  // requester 1
  input  logic          rq1_req,
  input  logic          rq1_we,
  input  logic [AW-1:0] rq1_adr,
  input  logic [LW-1:0] rq1_len,
  input  logic [DW-1:0] rq1_dout,
  input  logic          rq1_wait,
  output logic          rq1_gnt,
  output logic          rq1_ack,
  output logic          rq1_done,
  output logic          rq1_err,
  // master interface
  output logic          mast_go,
  output logic          mast_we,
  output logic          mast_wait,
  output logic [AW-1:0] mast_adr,
  output logic [DW-1:0] mast_dout,
  input  logic [DW-1:0] mast_din,
  input  logic          mast_drdy,
  input  logic          mast_err,
  output logic [DW-1:0] rd_data
);

  localparam logic [AW-1:0] ADR_INC = AW'(DW / 8);
  localparam logic [LW-1:0] CNT_ONE = LW'(1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Registered state
  state_t        r_state;
  logic          r_last;   // index of the most recent winner
  logic [1:0]    r_gnt;    // one-hot owner, or zero
  logic [AW-1:0] r_adr;
  logic          r_we;
  logic [LW-1:0] r_cnt;    // words still to transfer
  logic [1:0]    r_done;
  logic [1:0]    r_err;

  // Next-state values
  state_t        w_state_next;
  logic          w_last_next;
  logic [1:0]    w_gnt_next;
  logic [AW-1:0] w_adr_next;
  logic          w_we_next;
  logic [LW-1:0] w_cnt_next;
  logic [1:0]    w_done_next;
  logic [1:0]    w_err_next;

  // Arbitration
  logic [1:0]    w_req;
  logic          w_win;
  logic [1:0]    w_win_oh;
  logic [AW-1:0] w_win_adr;
  logic [LW-1:0] w_win_len;
  logic          w_win_we;
  logic          w_busy;

  assign w_req = {rq1_req, rq0_req};

  // On a tie the requester that did not win last time goes first;
  // otherwise the single active requester wins.
  assign w_win     = (w_req == 2'b11) ? ~r_last : w_req[1];
  assign w_win_oh  = w_win ? 2'b10 : 2'b01;
  assign w_win_adr = w_win ? rq1_adr : rq0_adr;
  assign w_win_len = w_win ? rq1_len : rq0_len;
  assign w_win_we  = w_win ? rq1_we  : rq0_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_gnt   <= '0;
      r_adr   <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_gnt   <= w_gnt_next;
      r_adr   <= w_adr_next;
      r_we    <= w_we_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_gnt_next   = r_gnt;
    w_adr_next   = r_adr;
    w_we_next    = r_we;
    w_cnt_next   = r_cnt;
    w_done_next  = '0;
    w_err_next   = '0;

    case (r_state)
      ST_IDLE: begin
        // Bus responses arriving while idle are deliberately ignored.
        if (w_req != 2'b00) begin
          w_last_next = w_win;
          w_adr_next  = w_win_adr;
          w_we_next   = w_win_we;
          w_cnt_next  = w_win_len;
          if (w_win_len == '0) begin
            // Empty burst: report completion without touching the bus.
            w_done_next = w_win_oh;
          end else begin
            w_gnt_next   = w_win_oh;
            w_state_next = ST_BUSY;
          end
        end
      end

      ST_BUSY: begin
        if (mast_err) begin
          // Error wins over a simultaneous drdy; address and count freeze.
          w_err_next   = r_gnt;
          w_gnt_next   = '0;
          w_state_next = ST_IDLE;
        end else if (mast_drdy) begin
          w_adr_next = r_adr + ADR_INC;
          w_cnt_next = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            w_done_next  = r_gnt;
            w_gnt_next   = '0;
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_gnt_next   = '0;
      end
    endcase
  end

  assign w_busy = (r_state == ST_BUSY);

  assign mast_go   = w_busy;
  assign mast_we   = w_busy & r_we;
  assign mast_adr  = w_busy ? r_adr : '0;
  assign mast_wait = (r_gnt[0] & rq0_wait) | (r_gnt[1] & rq1_wait);
  assign mast_dout = r_gnt[0] ? rq0_dout :
                     r_gnt[1] ? rq1_dout : '0;

  assign rq0_gnt  = r_gnt[0];
  assign rq1_gnt  = r_gnt[1];
  assign rq0_ack  = mast_drdy & r_gnt[0];
  assign rq1_ack  = mast_drdy & r_gnt[1];
  assign rq0_done = r_done[0];
  assign rq1_done = r_done[1];
  assign rq0_err  = r_err[0];
  assign rq1_err  = r_err[1];

  assign rd_data = mast_din;

endmodule

// File: tb/tb_wb_dma_mast_arb.sv
// -----------------------------------------------------------------------------
// tb_wb_dma_mast_arb
//
// Self-checking bench for wb_dma_mast_arb. Directed scenario tasks plus a
// randomized burst sequence checked against a burst-level model (winner
// choice, address = start + 4*word, done/err outcome per burst).
// -----------------------------------------------------------------------------
module tb_wb_dma_mast_arb;

  logic        clk;
  logic        rst;
  logic        rq0_req, rq0_we, rq0_wait;
  logic [31:0] rq0_adr, rq0_dout;
  logic [7:0]  rq0_len;
  logic        rq0_gnt, rq0_ack, rq0_done, rq0_err;
  logic        rq1_req, rq1_we, rq1_wait;
  logic [31:0] rq1_adr, rq1_dout;
  logic [7:0]  rq1_len;
  logic        rq1_gnt, rq1_ack, rq1_done, rq1_err;
  logic        mast_go, mast_we, mast_wait;
  logic [31:0] mast_adr, mast_dout, mast_din, rd_data;
  logic        mast_drdy, mast_err;

  int n_checks;
  int n_fail;
  bit m_last;   // model: index of the most recent winner

  wb_dma_mast_arb #(.AW(32), .DW(32), .LW(8)) dut (
    .clk(clk), .rst(rst),
    .rq0_req(rq0_req), .rq0_we(rq0_we), .rq0_adr(rq0_adr), .rq0_len(rq0_len),
    .rq0_dout(rq0_dout), .rq0_wait(rq0_wait), .rq0_gnt(rq0_gnt), .rq0_ack(rq0_ack),
    .rq0_done(rq0_done), .rq0_err(rq0_err),
    .rq1_req(rq1_req), .rq1_we(rq1_we), .rq1_adr(rq1_adr), .rq1_len(rq1_len),
    .rq1_dout(rq1_dout), .rq1_wait(rq1_wait), .rq1_gnt(rq1_gnt), .rq1_ack(rq1_ack),
    .rq1_done(rq1_done), .rq1_err(rq1_err),
    .mast_go(mast_go), .mast_we(mast_we), .mast_wait(mast_wait), .mast_adr(mast_adr),
    .mast_dout(mast_dout), .mast_din(mast_din), .mast_drdy(mast_drdy),
    .mast_err(mast_err), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next active edge; inputs are driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rq0_req = 0; rq0_we = 0; rq0_wait = 0; rq0_adr = 0; rq0_dout = 0; rq0_len = 0;
    rq1_req = 0; rq1_we = 0; rq1_wait = 0; rq1_adr = 0; rq1_dout = 0; rq1_len = 0;
    mast_din = 0; mast_drdy = 0; mast_err = 0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({mast_go, mast_we, rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq0_err, rq1_err} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=00000000",
               {mast_go, mast_we, rq0_gnt, rq1_gnt, rq0_done, rq1_done, rq0_err, rq1_err});
    end
    n_checks++;
    if (mast_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_adr got=%h exp=00000000", mast_adr);
    end
    tick();
    rst = 1'b1;
    m_last = 1'b1;
    tick();
    $display("test_reset complete");
  endtask

  task automatic test_single_read();
    rq0_req = 1; rq0_adr = 32'h100; rq0_len = 3; rq0_we = 0;
    mast_drdy = 1; mast_err = 0;
    @(negedge clk);
    n_checks++;
    if (mast_go !== 1'b0) begin n_fail++; $display("FAIL sr_idle_go got=%b exp=0", mast_go); end
    tick();
    rq0_req = 0;
    m_last = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({mast_go, rq0_gnt, rq0_ack, rq0_done, mast_we} !== 5'b11100) begin
        n_fail++;
        $display("FAIL sr_ctrl word=%0d got=%b exp=11100", k, {mast_go, rq0_gnt, rq0_ack, rq0_done, mast_we});
      end
      n_checks++;
      if (mast_adr !== 32'h100 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL sr_adr word=%0d got=%h exp=%h", k, mast_adr, 32'h100 + 32'(4 * k));
      end
      tick();
    end
    mast_drdy = 0;
    @(negedge clk);
    n_checks++;
    if ({rq0_done, rq0_gnt, mast_go} !== 3'b100) begin
      n_fail++;
      $display("FAIL sr_done got=%b exp=100", {rq0_done, rq0_gnt, mast_go});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rq0_done !== 1'b0) begin n_fail++; $display("FAIL sr_done_pulse got=%b exp=0", rq0_done); end
    tick();
    $display("test_single_read complete");
  endtask

  task automatic test_round_robin();
    bit cur;
    rq0_req = 1; rq0_len = 1; rq0_adr = 32'h40;
    rq1_req = 1; rq1_len = 1; rq1_adr = 32'h80;
    mast_drdy = 1;
    cur = ~m_last;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_checks++;
      if (c % 2 == 0) begin
        if ({rq1_gnt, rq0_gnt} !== 2'b00) begin
          n_fail++;
          $display("FAIL rr_idle cyc=%0d got=%b exp=00", c, {rq1_gnt, rq0_gnt});
        end
      end else begin
        if ({rq1_gnt, rq0_gnt} !== (cur ? 2'b10 : 2'b01)) begin
          n_fail++;
          $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, {rq1_gnt, rq0_gnt}, cur ? 2'b10 : 2'b01);
        end
        $display("rr grant to rq%0d", cur);
        m_last = cur;
        cur = ~cur;
      end
      tick();
    end
    rq0_req = 0; rq1_req = 0; mast_drdy = 0;
    tick();
    $display("test_round_robin complete");
  endtask

  task automatic test_stall();
    rq1_req = 1; rq1_we = 1; rq1_adr = 32'h300; rq1_len = 2; rq1_dout = 32'hA5A5_0001;
    mast_drdy = 0;
    tick();
    rq1_req = 0;
    m_last = 1;
    for (int i = 0; i < 3; i++) begin
      rq1_wait = 1;
      @(negedge clk);
      n_checks++;
      if ({mast_wait, mast_go, mast_we, rq1_gnt} !== 4'b1111) begin
        n_fail++;
        $display("FAIL st_ctrl cyc=%0d got=%b exp=1111", i, {mast_wait, mast_go, mast_we, rq1_gnt});
      end
      n_checks++;
      if (mast_adr !== 32'h300 || mast_dout !== 32'hA5A5_0001) begin
        n_fail++;
        $display("FAIL st_hold cyc=%0d adr=%h dout=%h exp=00000300/a5a50001", i, mast_adr, mast_dout);
      end
      tick();
    end
    rq1_wait = 0;
    mast_drdy = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (mast_wait !== 1'b0 || rq1_ack !== 1'b1 || mast_adr !== 32'h300 + 32'(4 * k)) begin
        n_fail++;
        $display("FAIL st_word k=%0d wait=%b ack=%b adr=%h exp wait=0 ack=1 adr=%h",
                 k, mast_wait, rq1_ack, mast_adr, 32'h300 + 32'(4 * k));
      end
      tick();
    end
    mast_drdy = 0;
    @(negedge clk);
    n_checks++;
    if ({rq1_done, mast_go, rq1_gnt} !== 3'b100) begin
      n_fail++;
      $display("FAIL st_done got=%b exp=100", {rq1_done, mast_go, rq1_gnt});
    end
    tick();
    rq1_we = 0;
    $display("test_stall complete");
  endtask

  task automatic test_error_abort();
    rq0_req = 1; rq0_adr = 32'h200; rq0_len = 4; rq0_we = 0;
    tick();
    rq0_req = 0;
    m_last = 0;
    rq1_req = 1; rq1_adr = 32'h400; rq1_len = 1; rq1_we = 0;
    mast_drdy = 1; mast_err = 0;
    @(negedge clk);
    tick();
    mast_err = 1;
    @(negedge clk);
    n_checks++;
    if (mast_adr !== 32'h204 || rq0_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL ea_word2 adr=%h gnt0=%b exp=00000204/1", mast_adr, rq0_gnt);
    end
    tick();
    mast_err = 0; mast_drdy = 0;
    @(negedge clk);
    n_checks++;
    if ({rq0_err, rq0_done, mast_go, rq0_gnt, rq1_gnt} !== 5'b10000) begin
      n_fail++;
      $display("FAIL ea_abort got=%b exp=10000", {rq0_err, rq0_done, mast_go, rq0_gnt, rq1_gnt});
    end
    tick();
    rq1_req = 0;
    m_last = 1;
    mast_drdy = 1;
    @(negedge clk);
    n_checks++;
    if ({rq1_gnt, mast_go, rq1_ack, rq0_err} !== 4'b1110 || mast_adr !== 32'h400) begin
      n_fail++;
      $display("FAIL ea_next got=%b adr=%h exp=1110 adr=00000400",
               {rq1_gnt, mast_go, rq1_ack, rq0_err}, mast_adr);
    end
    tick();
    mast_drdy = 0;
    @(negedge clk);
    n_checks++;
    if (rq1_done !== 1'b1) begin n_fail++; $display("FAIL ea_next_done got=%b exp=1", rq1_done); end
    tick();
    $display("test_error_abort complete");
  endtask

  task automatic test_len_zero();
    rq0_req = 1; rq0_len = 0; rq0_adr = 32'h500;
    mast_drdy = 1;
    tick();
    rq0_req = 0;
    m_last = 0;
    @(negedge clk);
    n_checks++;
    if ({rq0_done, mast_go} !== 2'b10) begin
      n_fail++;
      $display("FAIL lz_done got=%b exp=10", {rq0_done, mast_go});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({rq0_done, mast_go, rq0_ack} !== 3'b000) begin
      n_fail++;
      $display("FAIL lz_after got=%b exp=000", {rq0_done, mast_go, rq0_ack});
    end
    mast_drdy = 0;
    tick();
    $display("test_len_zero complete");
  endtask

  task automatic test_addr_wrap();
    rq1_req = 1; rq1_adr = 32'hFFFF_FFFC; rq1_len = 2;
    mast_drdy = 1;
    tick();
    rq1_req = 0;
    m_last = 1;
    @(negedge clk);
    n_checks++;
    if (mast_adr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_adr0 got=%h exp=fffffffc", mast_adr); end
    tick();
    @(negedge clk);
    n_checks++;
    if (mast_adr !== 32'h0 || mast_go !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_adr1 adr=%h go=%b exp=00000000/1", mast_adr, mast_go);
    end
    tick();
    mast_drdy = 0;
    @(negedge clk);
    n_checks++;
    if (rq1_done !== 1'b1) begin n_fail++; $display("FAIL wr_done got=%b exp=1", rq1_done); end
    tick();
    $display("test_addr_wrap complete");
  endtask

  task automatic test_random();
    logic [1:0]  exp_done, exp_err, r, oh;
    bit          prev_len0, win, aborted;
    logic [31:0] start;
    logic [7:0]  len;
    logic        we;
    int          k, cyc;
    exp_done = 0; exp_err = 0; prev_len0 = 0;
    for (int b = 0; b < 40; b++) begin
      r = 2'($urandom_range(1, 3));
      rq0_req = r[0]; rq1_req = r[1];
      rq0_adr = $urandom & 32'hFFFF_FFFC; rq1_adr = $urandom & 32'hFFFF_FFFC;
      rq0_len = 8'($urandom_range(0, 5)); rq1_len = 8'($urandom_range(0, 5));
      rq0_we = 1'($urandom_range(0, 1)); rq1_we = 1'($urandom_range(0, 1));
      mast_drdy = 1'($urandom_range(0, 1)); mast_err = 1'($urandom_range(0, 1));
      win   = (r == 2'b11) ? ~m_last : r[1];
      oh    = win ? 2'b10 : 2'b01;
      start = win ? rq1_adr : rq0_adr;
      len   = win ? rq1_len : rq0_len;
      we    = win ? rq1_we : rq0_we;
      @(negedge clk);
      n_checks++;
      if (mast_go !== 1'b0 || {rq1_done, rq0_done} !== exp_done || {rq1_err, rq0_err} !== exp_err) begin
        n_fail++;
        $display("FAIL rnd_idle b=%0d go=%b done=%b err=%b exp go=0 done=%b err=%b",
                 b, mast_go, {rq1_done, rq0_done}, {rq1_err, rq0_err}, exp_done, exp_err);
      end
      if (!prev_len0) begin
        n_checks++;
        if ({rq1_gnt, rq0_gnt} !== 2'b00) begin
          n_fail++;
          $display("FAIL rnd_idle_gnt b=%0d got=%b exp=00", b, {rq1_gnt, rq0_gnt});
        end
      end
      tick();
      m_last = win;
      if (len == 0) begin
        exp_done = oh; exp_err = 0; prev_len0 = 1;
        $display("rnd burst %0d rq%0d len=0", b, win);
        continue;
      end
      prev_len0 = 0; k = 0; cyc = 0; aborted = 0;
      while (k < int'(len) && !aborted && cyc < 64) begin
        rq0_req = 1'($urandom_range(0, 1)); rq1_req = 1'($urandom_range(0, 1));
        rq0_dout = $urandom; rq1_dout = $urandom; mast_din = $urandom;
        rq0_wait = 1'($urandom_range(0, 1)); rq1_wait = 1'($urandom_range(0, 1));
        mast_drdy = 1'($urandom_range(0, 1));
        mast_err = ($urandom_range(0, 15) == 0);
        @(negedge clk);
        n_checks++;
        if ({rq1_gnt, rq0_gnt} !== oh || mast_go !== 1'b1 || mast_we !== we ||
            mast_adr !== start + 32'(4 * k)) begin
          n_fail++;
          $display("FAIL rnd_bus b=%0d k=%0d gnt=%b go=%b we=%b adr=%h exp gnt=%b go=1 we=%b adr=%h",
                   b, k, {rq1_gnt, rq0_gnt}, mast_go, mast_we, mast_adr, oh, we, start + 32'(4 * k));
        end
        n_checks++;
        if (mast_dout !== (win ? rq1_dout : rq0_dout) || mast_wait !== (win ? rq1_wait : rq0_wait) ||
            {rq1_ack, rq0_ack} !== (mast_drdy ? oh : 2'b00) || rd_data !== mast_din ||
            {rq1_done, rq0_done, rq1_err, rq0_err} !== 4'b0000) begin
          n_fail++;
          $display("FAIL rnd_data b=%0d k=%0d dout=%h wait=%b ack=%b rd=%h pulses=%b exp dout=%h wait=%b ack=%b rd=%h pulses=0000",
                   b, k, mast_dout, mast_wait, {rq1_ack, rq0_ack}, rd_data,
                   {rq1_done, rq0_done, rq1_err, rq0_err}, win ? rq1_dout : rq0_dout,
                   win ? rq1_wait : rq0_wait, mast_drdy ? oh : 2'b00, mast_din);
        end
        tick();
        if (mast_err) aborted = 1;
        else if (mast_drdy) k++;
        cyc++;
      end
      n_checks++;
      if (!aborted && k < int'(len)) begin
        n_fail++;
        $display("FAIL rnd_timeout b=%0d words=%0d exp=%0d", b, k, len);
      end
      exp_done = aborted ? 2'b00 : oh;
      exp_err  = aborted ? oh : 2'b00;
      $display("rnd burst %0d rq%0d len=%0d words=%0d %s", b, win, len, k, aborted ? "aborted" : "complete");
    end
    rq0_req = 0; rq1_req = 0; mast_drdy = 0; mast_err = 0; rq0_wait = 0; rq1_wait = 0;
    @(negedge clk);
    n_checks++;
    if ({rq1_done, rq0_done} !== exp_done || {rq1_err, rq0_err} !== exp_err) begin
      n_fail++;
      $display("FAIL rnd_last done=%b err=%b exp done=%b err=%b",
               {rq1_done, rq0_done}, {rq1_err, rq0_err}, exp_done, exp_err);
    end
    tick();
    $display("test_random complete");
  endtask

  task automatic test_async_reset();
    rq0_req = 1; rq1_req = 0; rq0_len = 4; rq0_adr = 32'h600; rq0_we = 1;
    rq0_dout = 32'h1234_5678; mast_drdy = 0;
    tick();
    rq0_req = 0;
    @(negedge clk);
    n_checks++;
    if (mast_go !== 1'b1) begin n_fail++; $display("FAIL ar_busy got=%b exp=1", mast_go); end
    mast_drdy = 1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mast_go, mast_we, rq0_gnt, rq1_gnt, rq0_ack, rq0_done, rq0_err, mast_wait} !== 8'h00 ||
        mast_adr !== 32'h0 || mast_dout !== 32'h0) begin
      n_fail++;
      $display("FAIL ar_clear ctrl=%b adr=%h dout=%h exp ctrl=00000000 adr=0 dout=0",
               {mast_go, mast_we, rq0_gnt, rq1_gnt, rq0_ack, rq0_done, rq0_err, mast_wait},
               mast_adr, mast_dout);
    end
    mast_drdy = 0;
    rq0_req = 1; rq1_req = 1; rq0_len = 1; rq1_len = 1;
    tick();
    rst = 1'b1;
    m_last = 1;
    @(negedge clk);
    n_checks++;
    if (mast_go !== 1'b0) begin n_fail++; $display("FAIL ar_idle got=%b exp=0", mast_go); end
    tick();
    rq0_req = 0; rq1_req = 0;
    @(negedge clk);
    n_checks++;
    if ({rq1_gnt, rq0_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL ar_tie got=%b exp=01", {rq1_gnt, rq0_gnt});
    end
    tick();
    $display("test_async_reset complete");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_error_abort();
    test_len_zero();
    test_addr_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
